// File: rtl/psum_merge_node.sv
// Partial-sum merge endpoint: sums NUM_PSUM row partials per output pixel and queues ofmap packets to memory.
// Optional build macro PSUM_MERGE_SAT_EN makes every addition saturate at 8'hFF instead of wrapping.
module psum_merge_node #(
  parameter logic [4:0] NODE_ID     = 5'd20,
  parameter logic [4:0] MEM_ID      = 5'd0,
  parameter int         NUM_PSUM    = 3,
  parameter int         OUT_ENTRIES = 25,
  parameter int         OFIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] in_pkt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_pkt,
  output logic        done,
  output logic        err_idx
);

  // Handshake: a packet moves on either side exactly when valid and ready are both
  // high at a rising clk edge; ready never depends on the partner's valid.

  localparam int AW = (OUT_ENTRIES > 1) ? $clog2(OUT_ENTRIES) : 1;
  localparam int PW = $clog2(OFIFO_DEPTH);

  logic [7:0]    acc [OUT_ENTRIES];
  logic [2:0]    cnt [OUT_ENTRIES];
  logic [14:0]   fifo_mem [OFIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_count;
  logic [7:0]    emit_cnt;
  logic          done_q, err_q;

  logic [6:0]    in_idx;
  logic [4:0]    in_dst;
  logic [7:0]    in_psum;
  logic [AW-1:0] sel;
  logic          in_fire, pkt_ok, is_final, push, pop;
  logic [8:0]    sum9;
  logic [7:0]    new_sum;
  logic [14:0]   head;

  always_comb begin
    in_idx   = {in_pkt[9:8], in_pkt[19:15]};
    in_dst   = in_pkt[14:10];
    in_psum  = in_pkt[7:0];
    sel      = in_idx[AW-1:0];
    in_fire  = in_valid & in_ready;
    pkt_ok   = ({1'b0, in_idx} < 8'(OUT_ENTRIES)) && (in_dst == NODE_ID);
    sum9     = {1'b0, acc[sel]} + {1'b0, in_psum};
`ifdef PSUM_MERGE_SAT_EN
    new_sum  = sum9[8] ? 8'hFF : sum9[7:0];
`else
    new_sum  = sum9[7:0];
`endif
    is_final = cnt[sel] >= 3'(NUM_PSUM - 1);
    push     = in_fire & pkt_ok & is_final;
    pop      = out_valid & out_ready;
  end

  // Ready leaves one free slot so a final contribution can always be queued.
  assign in_ready  = rst_n & (fifo_count < (PW+1)'(OFIFO_DEPTH - 1));
  assign out_valid = (fifo_count != '0);
  assign head      = fifo_mem[rd_ptr];
  assign out_pkt   = out_valid ? {head[12:8], MEM_ID, head[14:13], head[7:0]} : 20'd0;
  assign done      = done_q;
  assign err_idx   = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_ENTRIES; i++) begin
        acc[i] <= 8'd0;
        cnt[i] <= 3'd0;
      end
      err_q <= 1'b0;
    end else if (in_fire) begin
      if (!pkt_ok) begin
        err_q <= 1'b1;
      end else if (is_final) begin
        acc[sel] <= 8'd0;
        cnt[sel] <= 3'd0;
      end else begin
        acc[sel] <= new_sum;
        cnt[sel] <= cnt[sel] + 3'd1;
      end
    end
  end

  // Storage needs no reset: out_pkt is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {in_idx, new_sum};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      emit_cnt   <= 8'd0;
      done_q     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      if (pop) begin
        emit_cnt <= emit_cnt + 8'd1;
        if (emit_cnt == 8'(OUT_ENTRIES - 1)) done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psum_merge_node.sv
// Directed bench for psum_merge_node: linear test steps plus an output scoreboard.
module tb_psum_merge_node;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_pkt;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_pkt;
  logic        done;
  logic        err_idx;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  psum_merge_node dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt),
    .done(done), .err_idx(err_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] mk_out(input int idx, input int sum);
    logic [6:0] i7;
    logic [7:0] s8;
    i7 = idx[6:0];
    s8 = sum[7:0];
    return {i7[4:0], 5'd0, i7[6:5], s8};
  endfunction

  // Drives one packet from a falling edge; it transfers on the following rising edge.
  task automatic send(input int idx, input int dst, input int ps);
    logic [6:0] i7;
    logic [4:0] d5;
    logic [7:0] p8;
    int n;
    i7 = idx[6:0];
    d5 = dst[4:0];
    p8 = ps[7:0];
    n  = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      in_valid = 1'b0;
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_pkt   = {i7[4:0], d5, i7[6:5], p8};
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #3;
    chk(tag, exp_q.size(), 32'd0);
  endtask

  task automatic pixel(input int idx, input int a, input int b, input int c, input int sum);
    exp_q.push_back(mk_out(idx, sum));
    send(idx, 20, a);
    send(idx, 20, b);
    send(idx, 20, c);
  endtask

  // Scoreboard: every output handshake must match the oldest expected packet.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_out", {12'd0, out_pkt}, 32'hFFFFFFFF);
      else chk("out_pkt", {12'd0, out_pkt}, {12'd0, exp_q.pop_front()});
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pkt    = 20'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pkt", {12'd0, out_pkt}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err_idx}, 32'd0);
    rst_n = 1'b1;

    // Basic three-term sum, with one-cycle output latency.
    pixel(7, 10, 20, 30, 60);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    chk("t1_latency", {31'd0, out_valid}, 32'd1);
    drain("t1_drain");

    // Overflow: 350 wraps to 94, or clamps to 255 when saturating.
`ifdef PSUM_MERGE_SAT_EN
    pixel(3, 200, 100, 50, 255);
`else
    pixel(3, 200, 100, 50, 94);
`endif
    idle();
    drain("t2_drain");

    // Backpressure: three queued sums block input; the fourth completes after release.
    out_ready = 1'b0;
    exp_q.push_back(mk_out(10, 6));
    exp_q.push_back(mk_out(11, 15));
    exp_q.push_back(mk_out(12, 24));
    exp_q.push_back(mk_out(13, 33));
    send(13, 20, 10);
    send(13, 20, 11);
    send(10, 20, 1); send(10, 20, 2); send(10, 20, 3);
    send(11, 20, 4); send(11, 20, 5); send(11, 20, 6);
    send(12, 20, 7); send(12, 20, 8); send(12, 20, 9);
    idle();
    #2;
    chk("t3_ready_low", {31'd0, in_ready}, 32'd0);
    chk("t3_head", {12'd0, out_pkt}, {12'd0, mk_out(10, 6)});
    repeat (3) @(negedge clk);
    #2;
    chk("t3_head_stable", {12'd0, out_pkt}, {12'd0, mk_out(10, 6)});
    @(negedge clk);
    out_ready = 1'b1;
    send(13, 20, 12);
    idle();
    drain("t3_drain");

    // Back-to-back interleaving of two pixels.
    exp_q.push_back(mk_out(0, 9));
    exp_q.push_back(mk_out(1, 12));
    send(0, 20, 1); send(1, 20, 2);
    send(0, 20, 3); send(1, 20, 4);
    send(0, 20, 5); send(1, 20, 6);
    idle();
    drain("t4_drain");

    // Dropped packets: out-of-range index and wrong destination leave no trace.
    send(30, 20, 5);
    send(25, 20, 5);
    idle();
    #2;
    chk("t5_err_idx", {31'd0, err_idx}, 32'd1);
    send(5, 9, 7);
    idle();
    #2;
    chk("t5_no_out", {31'd0, out_valid}, 32'd0);
    pixel(5, 1, 2, 3, 6);
    idle();
    drain("t5_drain");

    // Nine pixels emitted so far; sixteen more (idx 9..24) reach done.
    for (int k = 0; k < 15; k++) pixel(9 + k, k, 1, 2, k + 3);
    idle();
    drain("t5_drain15");
    chk("t5_done_pre", {31'd0, done}, 32'd0);
    pixel(24, 100, 27, 3, 130);
    idle();
    drain("t5_drain_last");
    chk("t5_done", {31'd0, done}, 32'd1);
    pixel(2, 4, 4, 4, 12);
    idle();
    drain("t5_after_done");
    chk("t5_done_sticky", {31'd0, done}, 32'd1);

    // Reset mid-accumulation discards the partial sum and clears status.
    send(4, 20, 5);
    send(4, 20, 6);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    chk("t6_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("t6_rst_done", {31'd0, done}, 32'd0);
    chk("t6_rst_err", {31'd0, err_idx}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pixel(4, 1, 1, 1, 3);
    idle();
    drain("t6_drain");
    chk("t6_done_clear", {31'd0, done}, 32'd0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
